// File: rtl/sfx_scheduler.sv
// Priority sound-effect scheduler: grants one of four requesters, steps its 4-note ROM
// sequence and drives the tone generator. Define SFX_MUSIC_LOOP_EN to make req[0] a looping level.
module sfx_scheduler #(
  parameter int N_REQ    = 4,
  parameter int NOTE_LEN = 3000000,
  parameter int GAP_LEN  = 375000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [8:0]       note_div,
  output logic [2:0]       note_oct,
  output logic             tone_en,
  output logic             busy,
  output logic             done
);

  localparam int TW = $clog2(NOTE_LEN);
  localparam logic [TW-1:0] TICK_LAST = TW'(NOTE_LEN - 1);
  localparam logic [TW-1:0] TICK_GAP  = TW'(NOTE_LEN - GAP_LEN);
`ifdef SFX_MUSIC_LOOP_EN
  localparam logic [N_REQ-1:0] LVL = N_REQ'(1);
`else
  localparam logic [N_REQ-1:0] LVL = '0;
`endif

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, pend_q, pend_d;
  logic [1:0]       slot_q, slot_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [8:0]       div_q, div_d;
  logic [2:0]       oct_q, oct_d;
  logic             ten_q, ten_d, done_q, done_d;

  logic [N_REQ-1:0] cand, win, above;
  logic [6:0]       note;
  logic             rest, play, restart, loop_ok;

  function automatic logic [N_REQ-1:0] top_bit(input logic [N_REQ-1:0] v);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++)
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    return r;
  endfunction

  function automatic logic [1:0] enc(input logic [N_REQ-1:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++)
      if (g[i]) r = 2'(i);
    return r;
  endfunction

  // {octave, idx}; idx 15 marks a rest
  function automatic logic [6:0] rom(input logic [1:0] seq, input logic [1:0] slot);
    logic [6:0] r;
    case ({seq, slot})
      4'b00_00: r = {3'd1, 4'd3};
      4'b00_01: r = {3'd1, 4'd7};
      4'b00_10: r = {3'd1, 4'd10};
      4'b00_11: r = {3'd2, 4'd3};
      4'b01_00: r = {3'd2, 4'd3};
      4'b01_01: r = {3'd2, 4'd5};
      4'b01_10: r = {3'd2, 4'd7};
      4'b10_00: r = {3'd4, 4'd0};
      4'b10_01: r = {3'd3, 4'd0};
      4'b10_10: r = {3'd2, 4'd0};
      4'b11_00: r = {3'd0, 4'd11};
      4'b11_10: r = {3'd0, 4'd11};
      default:  r = {3'd0, 4'd15};
    endcase
    return r;
  endfunction

  function automatic logic [8:0] div_of(input logic [3:0] idx);
    logic [8:0] r;
    case (idx)
      4'd0:    r = 9'd511;
      4'd1:    r = 9'd482;
      4'd2:    r = 9'd455;
      4'd3:    r = 9'd430;
      4'd4:    r = 9'd405;
      4'd5:    r = 9'd383;
      4'd6:    r = 9'd361;
      4'd7:    r = 9'd341;
      4'd8:    r = 9'd322;
      4'd9:    r = 9'd303;
      4'd10:   r = 9'd286;
      4'd11:   r = 9'd270;
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    slot_d  = slot_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    cand    = pend_q | req;
    win     = top_bit(cand);
    // bits strictly above the one-hot active requester
    above   = ~(grant_q | (grant_q - N_REQ'(1)));
    restart = |(req & grant_q & ~LVL);
    loop_ok = |(grant_q & LVL) && req[0] && (pend_q[N_REQ-1:1] == '0);
    case (state_q)
      S_IDLE: begin
        if (cand != '0) begin
          state_d = S_PLAY;
          grant_d = win;
          slot_d  = '0;
          tick_d  = '0;
        end
      end
      default: begin
        if (|(cand & above)) begin
          grant_d = win;
          slot_d  = '0;
          tick_d  = '0;
        end else if (restart) begin
          slot_d = '0;
          tick_d = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (slot_q != 2'd3) begin
            slot_d = slot_q + 2'd1;
          end else if (loop_ok) begin
            slot_d = '0;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            slot_d  = '0;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
    endcase
    pend_d = cand & ~grant_d;
    // outputs are registered from next-state values so they line up with the slot/tick they describe
    note  = rom(enc(grant_d), slot_d);
    rest  = (note[3:0] == 4'd15);
    play  = (state_d == S_PLAY) && !rest;
    div_d = play ? div_of(note[3:0]) : 9'd0;
    oct_d = play ? note[6:4] : 3'd0;
    ten_d = play && (tick_d < TICK_GAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      pend_q  <= '0;
      slot_q  <= '0;
      tick_q  <= '0;
      div_q   <= '0;
      oct_q   <= '0;
      ten_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      slot_q  <= slot_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      oct_q   <= oct_d;
      ten_q   <= ten_d;
      done_q  <= done_d;
    end
  end

  assign grant    = grant_q;
  assign note_div = div_q;
  assign note_oct = oct_q;
  assign tone_en  = ten_q;
  assign busy     = (state_q == S_PLAY);
  assign done     = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed vector table plus randomized traffic against a
// position-based reference model (active requester + linear position in a 32-cycle sequence).
module tb_sfx_scheduler;
  localparam int NL = 8;
  localparam int GL = 2;
`ifdef SFX_MUSIC_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [8:0] note_div;
  logic [2:0] note_oct;
  logic       tone_en, busy, done;

  sfx_scheduler #(.N_REQ(4), .NOTE_LEN(NL), .GAP_LEN(GL)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .note_div(note_div),
    .note_oct(note_oct), .tone_en(tone_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  int OCT [4][4] = '{'{1, 1, 1, 2}, '{2, 2, 2, 0}, '{4, 3, 2, 0}, '{0, 0, 0, 0}};
  int IDX [4][4] = '{'{3, 7, 10, 3}, '{3, 5, 7, 15}, '{0, 0, 0, 15}, '{11, 15, 11, 15}};
  int DIV [12]   = '{511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270};

  int         m_act = -1, m_pos = 0;
  logic [3:0] m_pend = '0;
  bit         m_done = 1'b0;

  function automatic int hi(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] r);
    logic [3:0] cand;
    int top;
    bit lvl;
    m_done = 1'b0;
    if (rst) begin
      m_act = -1; m_pos = 0; m_pend = '0;
    end else begin
      cand = m_pend | r;
      top  = hi(cand);
      lvl  = LOOP && (m_act == 0);
      if (m_act < 0) begin
        if (top >= 0) begin m_act = top; m_pos = 0; end
      end else if (top > m_act) begin
        m_act = top; m_pos = 0;
      end else if (r[m_act] && !lvl) begin
        m_pos = 0;
      end else if (m_pos == 4*NL-1) begin
        if (lvl && r[0] && m_pend[3:1] == 3'b000) m_pos = 0;
        else begin m_act = -1; m_done = 1'b1; end
      end else begin
        m_pos++;
      end
      m_pend = cand;
      if (m_act >= 0) m_pend[m_act] = 1'b0;
    end
  endtask

  // {grant, div, oct, tone_en, busy, done}
  function automatic logic [18:0] m_out();
    logic [3:0] g;
    int s, idx;
    if (m_act < 0) return {4'd0, 9'd0, 3'd0, 1'b0, 1'b0, m_done};
    g   = 4'b0001 << m_act;
    s   = m_pos / NL;
    idx = IDX[m_act][s];
    if (idx == 15) return {g, 9'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    return {g, 9'(DIV[idx]), 3'(OCT[m_act][s]), ((m_pos % NL) < NL-GL), 1'b1, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] r);
    reset = rst;
    req   = r;
    @(posedge clk);
    #1;
    model_step(rst, r);
    chk("model", {13'd0, grant, note_div, note_oct, tone_en, busy, done}, {13'd0, m_out()});
  endtask

  typedef struct {
    int         adv;
    logic [3:0] rq;
    logic [3:0] g;
    logic [8:0] dv;
    logic [2:0] oc;
    logic       te;
    logic       dn;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // seq0 single play
    tbl.push_back('{1,  4'b0001, 4'b0001, 9'd430, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{6,  4'b0000, 4'b0001, 9'd430, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{1,  4'b0000, 4'b0001, 9'd430, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{1,  4'b0000, 4'b0001, 9'd341, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{24, 4'b0000, 4'b0000, 9'd0,   3'd0, 1'b0, 1'b1});
    // simultaneous 0110: seq2 first, seq1 served after done
    tbl.push_back('{1,  4'b0110, 4'b0100, 9'd511, 3'd4, 1'b1, 1'b0});
    tbl.push_back('{32, 4'b0000, 4'b0000, 9'd0,   3'd0, 1'b0, 1'b1});
    tbl.push_back('{1,  4'b0000, 4'b0010, 9'd430, 3'd2, 1'b1, 1'b0});
    // preempt seq1 at slot 1 tick 3 by seq3; seq1 dropped
    tbl.push_back('{11, 4'b0000, 4'b0010, 9'd383, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1,  4'b1000, 4'b1000, 9'd270, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{32, 4'b0000, 4'b0000, 9'd0,   3'd0, 1'b0, 1'b1});
    tbl.push_back('{1,  4'b0000, 4'b0000, 9'd0,   3'd0, 1'b0, 1'b0});
    // seq2 re-request at slot 2 restarts; done 32 cycles later
    tbl.push_back('{1,  4'b0100, 4'b0100, 9'd511, 3'd4, 1'b1, 1'b0});
    tbl.push_back('{16, 4'b0000, 4'b0100, 9'd511, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1,  4'b0100, 4'b0100, 9'd511, 3'd4, 1'b1, 1'b0});
    tbl.push_back('{31, 4'b0000, 4'b0100, 9'd0,   3'd0, 1'b0, 1'b0});
    tbl.push_back('{1,  4'b0000, 4'b0000, 9'd0,   3'd0, 1'b0, 1'b1});
    // seq3 into its rest slot
    tbl.push_back('{1,  4'b1000, 4'b1000, 9'd270, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{8,  4'b0000, 4'b1000, 9'd0,   3'd0, 1'b0, 1'b0});

    step(1'b1, 4'b0000);
    step(1'b1, 4'b1111);
    chk("reset_state", {13'd0, grant, note_div, note_oct, tone_en, busy, done}, 32'd0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].adv; k++) step(1'b0, (k == 0) ? tbl[i].rq : 4'b0000);
      chk($sformatf("vec%0d", i), {12'd0, grant, note_div, note_oct, tone_en, done},
          {12'd0, tbl[i].g, tbl[i].dv, tbl[i].oc, tbl[i].te, tbl[i].dn});
    end

    // reset mid rest slot with a lower request pending
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0100);
    chk("reset_mid", {13'd0, grant, note_div, note_oct, tone_en, busy, done}, 32'd0);
    repeat (3) step(1'b0, 4'b0000);
    chk("pend_cleared", {27'd0, grant, busy}, 32'd0);

    // seq0 pulse plays once
    step(1'b0, 4'b0001);
    repeat (31) step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    chk("seq0_done", {27'd0, grant, done}, 32'd1);
    step(1'b0, 4'b0000);
    chk("seq0_once", {27'd0, grant, busy}, 32'd0);

`ifdef SFX_MUSIC_LOOP_EN
    repeat (33) step(1'b0, 4'b0001);
    chk("loop_wrap", {18'd0, grant, note_div, done}, {18'd0, 4'b0001, 9'd430, 1'b0});
    repeat (31) step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    chk("loop_end", {27'd0, grant, done}, 32'd1);
`endif

    for (int c = 0; c < 4000; c++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step($urandom_range(0, 599) == 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
Arbitrates between game-event sound requesters (music, jump, shoot, hit) for the single square-wave tone generator. Each requester owns a fixed 4-note sequence in an internal ROM. The block sequences the granted effect note by note and drives the generator's divider, octave and enable inputs. It sits between the game logic (request pulses) and the tone generator (speaker output).

Parameters:
N_REQ, 4, number of requesters; fixed at 4 because the ROM holds 4 sequences.
NOTE_LEN, 3000000, clk cycles per note slot; must be greater than GAP_LEN.
GAP_LEN, 375000, silent cycles at the end of each slot (articulation).

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
req  in  4  one-cycle request pulses; bit 3 has highest priority
grant  out  4  one-hot active requester; 0 when idle
note_div  out  9  half-period divider for the tone generator
note_oct  out  3  octave 0..5 for the tone generator
tone_en  out  1  generator enable; 0 means silence
busy  out  1  high in PLAY
done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset values: grant=0, note_div=0, note_oct=0, tone_en=0, busy=0, done=0. Reset also clears all pending bits and the slot and tick counters. Reset wins over req in the same cycle. Reset mid-PLAY returns to IDLE next cycle.
- Pending register pend[3:0]:
  - Set by req.
  - Cleared for the winner when it is granted.
- States:
  - IDLE: if (pend|req)!=0, next cycle go to PLAY. Grant the highest set bit, slot=0, tick=0. Latency is 1 cycle from the req pulse to grant, note outputs and tone_en.
  - PLAY: tick counts 0..NOTE_LEN-1.
    - tone_en=1 while tick<NOTE_LEN-GAP_LEN and the note is not a rest; otherwise tone_en=0.
    - At tick=NOTE_LEN-1: if slot<3, slot++, tick=0 and note outputs update next cycle. If slot=3, go to IDLE, grant=0, tone_en=0, done=1 for that one cycle.
- Preemption: a req (or pend) bit strictly higher than the active requester, seen in any PLAY cycle, switches next cycle to the new requester at slot 0, tick 0. The preempted effect is dropped (not re-queued). done is not pulsed on preemption.
- Re-request of the active requester during PLAY restarts its sequence at slot 0 next cycle.
- Lower-priority req during PLAY stays pending. It is served from IDLE after done, highest pending first.
- Simultaneous reqs: highest bit is granted; the others stay pending.
- Note ROM entries are (octave, idx); idx 15 = rest.
  - seq0 music: (1,3) (1,7) (1,10) (2,3)
  - seq1 jump: (2,3) (2,5) (2,7) rest
  - seq2 shoot: (4,0) (3,0) (2,0) rest
  - seq3 hit: (0,11) rest (0,11) rest
- Divider table, idx -> note_div: 0:511 1:482 2:455 3:430 4:405 5:383 6:361 7:341 8:322 9:303 10:286 11:270.
- Rest slot: note_div=0, note_oct=0, tone_en=0 for the whole slot.
- All outputs are registered. note_div/note_oct change only on a slot boundary or a grant change.

Optional Feature:
SFX_MUSIC_LOOP_EN
- Defined: req[0] is a level enable. At the end of seq0 slot 3, if req[0]=1 and pend[3:1]=0, slot wraps to 0 with no IDLE cycle and no done pulse. When req[0]=0 at the end, the sequence finishes normally with done. seq0 resumes automatically from IDLE while req[0] stays high.
- Undefined: req[0] is a pulse like the other bits; seq0 plays once.

Test Plan:
Use NOTE_LEN=8, GAP_LEN=2.
1. reset, then req=0001 pulse at cycle 0 -> cycle 1: grant=0001, note_div=430, note_oct=1, tone_en=1.
   - cycles 7-8: tone_en=0.
   - cycle 9: note_div=341.
   - cycle 33: done=1, grant=0.
2. req=0110 in a single cycle -> grant=0100 playing (4,511). After done (cycle 33), IDLE; cycle 34: grant=0010 with (2,430).
3. seq1 playing, req=1000 at slot 1 tick 3 -> next cycle: grant=1000, note_div=270, note_oct=0. No done pulse. seq1 is not replayed afterwards.
4. seq2 playing, req=0100 again at slot 2 -> next cycle: slot 0, note_div=511, note_oct=4. Total done arrives 32 cycles after the restart.
5. seq3 slot 1 (rest) -> tone_en=0 and note_div=0 for all 8 cycles. reset asserted mid-slot -> next cycle all outputs 0 and pend cleared.
6. With SFX_MUSIC_LOOP_EN, req[0] held high -> seq0 wraps slot 3 -> slot 0 with no done pulse. req[0] dropped -> done once after slot 3. Without the macro, the same stimulus plays seq0 once per IDLE re-grant.
